// File: rtl/au_mac_seq.sv
`default_nettype none
// au_mac_seq: job sequencer and accumulator around an external packed multiplier unit (rev 1.0).
// Define AU_MAC_SAT_EN for a saturating accumulator; the default build wraps modulo 2^ACCWD.

typedef enum logic [2:0] {
   AU_XNOR = 3'd0,
   AU_M1   = 3'd1,
   AU_M2   = 3'd2,
   AU_M4   = 3'd3,
   AU_M8   = 3'd4
} au_mode_e;

typedef enum logic {
   NUMT_SIGNED   = 1'b0,
   NUMT_UNSIGNED = 1'b1
} num_t;

typedef struct packed {
   au_mode_e mode;
   num_t     inumt;
   num_t     wnumt;
} au_ctl_t;

module au_mac_seq #(
   parameter int ASUMDWD = 18,
   parameter int ACCWD   = 32,
   parameter int LENWD   = 10
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_cfg_valid,
   output logic                      o_cfg_ready,
   input  au_mode_e                  i_cfg_mode,
   input  num_t                      i_cfg_inumt,
   input  num_t                      i_cfg_wnumt,
   input  logic [LENWD-1:0]          i_cfg_len,
   input  logic                      i_pix_valid,
   output logic                      o_pix_ready,
   input  logic [15:0]               i_ipix,
   input  logic [15:0]               i_wpix,
   output au_ctl_t                   o_au_ctl,
   output logic [15:0]               o_au_ipix,
   output logic [15:0]               o_au_wpix,
   input  logic signed [ASUMDWD-1:0] i_au_sum,
   output logic                      o_acc_valid,
   input  logic                      i_acc_ready,
   output logic signed [ACCWD-1:0]   o_acc,
   output logic                      o_busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   state_e                   state;
   state_e                   state_nxt;
   au_ctl_t                  ctl;
   logic [LENWD-1:0]         cnt;
   logic                     s1_valid;
   logic [15:0]              s1_ipix;
   logic [15:0]              s1_wpix;
   logic signed [ACCWD-1:0]  acc;
   logic signed [ACCWD-1:0]  acc_nxt;
   logic                     cfg_rdy;
   logic                     pix_rdy;
   logic                     acc_vld;
   logic                     cfg_hs;
   logic                     pix_hs;

   always_comb begin
      state_nxt = state;
      cfg_rdy   = 1'b0;
      pix_rdy   = 1'b0;
      acc_vld   = 1'b0;
      case (state)
         S_IDLE: begin
            cfg_rdy = 1'b1;
            if (i_cfg_valid) state_nxt = S_RUN;
         end
         S_RUN: begin
            pix_rdy = 1'b1;
            if (i_pix_valid && cnt == '0) state_nxt = S_DRAIN;
         end
         S_DRAIN: state_nxt = S_DONE;
         S_DONE: begin
            acc_vld = 1'b1;
            if (i_acc_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign cfg_hs = i_cfg_valid & cfg_rdy;
   assign pix_hs = i_pix_valid & pix_rdy;

`ifdef AU_MAC_SAT_EN
   // Sum is formed one bit wider than either operand so the clamp sees the true value.
   localparam int SW = ((ACCWD > ASUMDWD) ? ACCWD : ASUMDWD) + 1;
   localparam logic signed [SW-1:0] MAXV = {{(SW-ACCWD+1){1'b0}}, {(ACCWD-1){1'b1}}};
   localparam logic signed [SW-1:0] MINV = {{(SW-ACCWD+1){1'b1}}, {(ACCWD-1){1'b0}}};
   logic signed [SW-1:0] sum_w;

   assign sum_w = SW'(acc) + SW'(i_au_sum);

   always_comb begin
      acc_nxt = sum_w[ACCWD-1:0];
      if (sum_w > MAXV)      acc_nxt = MAXV[ACCWD-1:0];
      else if (sum_w < MINV) acc_nxt = MINV[ACCWD-1:0];
   end
`else
   assign acc_nxt = acc + ACCWD'(i_au_sum);
`endif

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state    <= S_IDLE;
         ctl      <= '0;
         cnt      <= '0;
         s1_valid <= 1'b0;
         s1_ipix  <= '0;
         s1_wpix  <= '0;
         acc      <= '0;
      end else begin
         state    <= state_nxt;
         s1_valid <= pix_hs;
         s1_ipix  <= pix_hs ? i_ipix : 16'h0000;
         s1_wpix  <= pix_hs ? i_wpix : 16'h0000;
         if (cfg_hs) begin
            ctl <= {i_cfg_mode, i_cfg_inumt, i_cfg_wnumt};
            cnt <= i_cfg_len;
            acc <= '0;
         end else begin
            if (pix_hs && cnt != '0) cnt <= cnt - 1'b1;
            if (s1_valid) acc <= acc_nxt;
         end
      end
   end

   // Outputs are forced low while reset is held, whatever the registered state.
   assign o_cfg_ready = i_rst_n & cfg_rdy;
   assign o_pix_ready = i_rst_n & pix_rdy;
   assign o_acc_valid = i_rst_n & acc_vld;
   assign o_busy      = i_rst_n & (state != S_IDLE);
   assign o_acc       = i_rst_n ? acc : '0;
   assign o_au_ctl    = i_rst_n ? ctl : '0;
   assign o_au_ipix   = i_rst_n ? s1_ipix : 16'h0000;
   assign o_au_wpix   = i_rst_n ? s1_wpix : 16'h0000;

endmodule

`default_nettype wire

// File: doc/au_mac_seq.md
AU_MAC_SEQ -- requirements
Module: au_mac_seq

Interface
REQ-001 SHALL have parameter ASUMDWD, default 18, width of the signed packed-multiplier sum.
REQ-002 SHALL have parameter ACCWD, default 32, width of the signed accumulator and result.
REQ-003 SHALL have parameter LENWD, default 10, width of the beat-count field.
REQ-004 SHALL have port i_clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port i_rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have ports i_cfg_valid (input, 1) and o_cfg_ready (output, 1): job-configuration handshake.
REQ-007 SHALL have port i_cfg_mode, input, AuCtl mode type: precision mode, one of XNOR/M1/M2/M4/M8.
REQ-008 SHALL have ports i_cfg_inumt and i_cfg_wnumt, input, NumT type: SIGNED/UNSIGNED for input and weight operands.
REQ-009 SHALL have port i_cfg_len, input, LENWD bits: beats per job minus one.
REQ-010 SHALL have ports i_pix_valid (input, 1), o_pix_ready (output, 1), i_ipix (input, 16) and i_wpix (input, 16): packed operand stream.
REQ-011 SHALL have ports o_au_ctl (output, AuCtl), o_au_ipix (output, 16) and o_au_wpix (output, 16): drive to the packed multiplier unit.
REQ-012 SHALL have port i_au_sum, input, signed ASUMDWD bits: combinational sum from the packed multiplier unit.
REQ-013 SHALL have ports o_acc_valid (output, 1), i_acc_ready (input, 1) and o_acc (output, signed ACCWD): result handshake.
REQ-014 SHALL have port o_busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-015 SHALL implement a four-state FSM: IDLE, RUN, DRAIN, DONE.
REQ-016 IDLE: o_cfg_ready=1. A cfg handshake SHALL latch mode, inumt, wnumt and len, clear the accumulator, load the beat counter with len, and enter RUN.
REQ-017 RUN: o_pix_ready=1 and o_cfg_ready=0. Each pix handshake SHALL register the operands into stage 1 and decrement the counter; the handshake with counter==0 SHALL move the FSM to DRAIN.
REQ-018 o_au_ctl SHALL be held constant from the cfg latch until the FSM returns to IDLE.
REQ-019 Stage 1 SHALL carry a valid bit; a cycle without a handshake SHALL clear it and zero o_au_ipix and o_au_wpix.
REQ-020 Stage 2: when the stage-1 valid bit is set, the accumulator SHALL add i_au_sum sign-extended to ACCWD; when it is clear, the accumulator SHALL hold.
REQ-021 DRAIN SHALL last exactly one cycle (last accumulate), then enter DONE.
REQ-022 o_acc_valid SHALL rise two cycles after the last pix handshake.
REQ-023 DONE: o_acc_valid=1 and o_acc=accumulator; o_acc SHALL remain stable until i_acc_ready=1, and that handshake SHALL return the FSM to IDLE.
REQ-024 o_pix_ready SHALL be 0 in DRAIN and DONE.
REQ-025 o_cfg_ready SHALL be 0 outside IDLE; i_cfg_valid outside IDLE SHALL be ignored.
REQ-026 len=0 SHALL produce a one-beat job; len=2^LENWD-1 SHALL produce 2^LENWD beats with no counter wrap.
REQ-027 A back-to-back job SHALL be accepted in the cycle after the DONE handshake (the IDLE cycle).

Reset
REQ-028 With i_rst_n=0 at a clock edge, the block SHALL enter IDLE and clear the accumulator, counter, stage-1 valid bit and operand registers.
REQ-029 During reset, outputs SHALL be: o_acc_valid=0, o_acc=0, o_pix_ready=0, o_cfg_ready=0, o_busy=0, o_au_ipix=0, o_au_wpix=0, o_au_ctl=all zero.
REQ-030 A reset asserted in any state, including mid-RUN, SHALL abort the job with no result emitted.

Configuration
REQ-031 Macro AU_MAC_SAT_EN defined: the accumulate SHALL saturate to [-2^(ACCWD-1), 2^(ACCWD-1)-1].
REQ-032 Macro AU_MAC_SAT_EN undefined: the accumulate SHALL wrap modulo 2^ACCWD.

Verification
REQ-033 M8 signed, len=0, ipix=16'h03FE, wpix=16'h0205 -> o_acc=-4 with o_acc_valid two cycles after the handshake.
REQ-034 M8 unsigned, len=3, four beats of ipix=16'h0A0A, wpix=16'h0303 -> o_acc=240.
REQ-035 Same job as REQ-034 with i_pix_valid low for 3 cycles between beats -> o_acc=240 and stage-1 valid low during the gaps.
REQ-036 i_acc_ready held low 5 cycles in DONE -> o_acc stable; o_pix_ready=0 and o_cfg_ready=0 throughout.
REQ-037 ACCWD=8, REQ-034 stimulus -> o_acc=127 with AU_MAC_SAT_EN defined; o_acc=-16 without it.
REQ-038 i_rst_n low for 1 cycle after 2 beats of a len=3 job -> IDLE with all outputs 0; a subsequent len=0 job returns the correct result.
